// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC register, word-addressed instruction memory, next-PC select
// Memory is preloaded in BOOT; a misaligned or out-of-range next PC parks the unit in FAULT until reset.
module instruction_fetch_unit #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          stall,
  input  logic          Jump,
  input  logic          Branch,
  input  logic          Zero,
  output logic [31:0]   Instr,
  output logic [5:0]    Opcode,
  output logic [5:0]    Funct,
  output logic [4:0]    Rs,
  output logic [4:0]    Rt,
  output logic [4:0]    Rd,
  output logic [15:0]   Imm,
  output logic [31:0]   PC,
  output logic [31:0]   PCPlus4,
  output logic          running,
  output logic          fault
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        running_q, fault_q;
  logic        mem_we;

  logic [31:0] mem [IMEM_DEPTH];
  logic [31:0] fetch_word;
  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] target;
  logic        target_bad;

  assign pc_plus4   = pc_q + 32'd4;
  assign fetch_word = mem[pc_q[AW+1:2]];
  assign br_offset  = {{14{fetch_word[15]}}, fetch_word[15:0], 2'b00};

  // Jump outranks a taken branch; stall is applied later, when choosing pc_d.
  always_comb begin
    target = pc_plus4;
    if (Jump) begin
      target = {pc_plus4[31:28], fetch_word[25:0], 2'b00};
    end else if (Branch && Zero) begin
      target = pc_plus4 + br_offset;
    end
  end

  assign target_bad = (target[1:0] != 2'b00) || (target[31:AW+2] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      running_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= (state_d == S_RUN);
      fault_q   <= (state_d == S_FAULT);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  if (start) state_d = S_RUN;
      S_RUN:   if (!stall && target_bad) state_d = S_FAULT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    mem_we = 1'b0;
    case (state_q)
      S_BOOT:  mem_we = load_en;
      S_RUN:   if (!stall && !target_bad) pc_d = target;
      default: ;
    endcase
  end

  // No reset on the array: a reset re-runs whatever program was loaded.
  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr] <= load_data;
  end

  assign Instr   = (state_q == S_RUN) ? fetch_word : 32'h0;
  assign Opcode  = Instr[31:26];
  assign Rs      = Instr[25:21];
  assign Rt      = Instr[20:16];
  assign Rd      = Instr[15:11];
  assign Imm     = Instr[15:0];
  assign Funct   = Instr[5:0];
  assign PC      = pc_q;
  assign PCPlus4 = pc_plus4;
  assign running = running_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed vector table plus randomized run against a behavioural fetch model
module tb_instruction_fetch_unit;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, load_en = 1'b0, stall = 1'b0;
  logic          Jump = 1'b0, Branch = 1'b0, Zero = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic [31:0]   Instr, PC, PCPlus4;
  logic [5:0]    Opcode, Funct;
  logic [4:0]    Rs, Rt, Rd;
  logic [15:0]   Imm;
  logic          running, fault;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .stall(stall),
    .Jump(Jump), .Branch(Branch), .Zero(Zero), .Instr(Instr),
    .Opcode(Opcode), .Funct(Funct), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm(Imm),
    .PC(PC), .PCPlus4(PCPlus4), .running(running), .fault(fault)
  );

  typedef struct {
    logic        stall, jump, branch, zero;
    logic [31:0] pc, instr;
    logic        run, flt;
  } vec_t;

  vec_t        vec[17];
  logic [31:0] prog[17];
  logic [31:0] m_mem[DEPTH];
  int          m_state;
  logic [31:0] m_pc, exp_instr, p4, nxt, w;
  int          off;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mkv(input logic s, j, b, z, input logic [31:0] pc, ins,
                               input logic r, f);
    vec_t v;
    v.stall = s; v.jump = j; v.branch = b; v.zero = z;
    v.pc = pc; v.instr = ins; v.run = r; v.flt = f;
    return v;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; load_en = 1'b0; stall = 1'b0; Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 17; i++) prog[i] = 32'h0;
    prog[0]  = 32'h2008_0005;
    prog[1]  = 32'h2009_0003;
    prog[2]  = 32'h0109_5020;
    prog[3]  = 32'h012A_5822;
    prog[4]  = 32'h1000_FFFE;
    prog[5]  = 32'h8D0B_0004;
    prog[8]  = 32'h0800_0010;
    prog[16] = 32'h0800_0100;

    vec[0]  = mkv(0, 0, 0, 0, 32'h00, prog[0], 1, 0);
    vec[1]  = mkv(0, 0, 0, 0, 32'h04, prog[1], 1, 0);
    vec[2]  = mkv(1, 0, 0, 0, 32'h08, prog[2], 1, 0);
    vec[3]  = mkv(1, 1, 0, 0, 32'h08, prog[2], 1, 0);
    vec[4]  = mkv(1, 0, 1, 1, 32'h08, prog[2], 1, 0);
    vec[5]  = mkv(0, 0, 0, 0, 32'h08, prog[2], 1, 0);
    vec[6]  = mkv(0, 0, 0, 0, 32'h0C, prog[3], 1, 0);
    vec[7]  = mkv(0, 0, 1, 1, 32'h10, prog[4], 1, 0);
    vec[8]  = mkv(0, 0, 0, 0, 32'h0C, prog[3], 1, 0);
    vec[9]  = mkv(0, 0, 1, 0, 32'h10, prog[4], 1, 0);
    vec[10] = mkv(0, 0, 0, 0, 32'h14, prog[5], 1, 0);
    vec[11] = mkv(0, 0, 0, 0, 32'h18, prog[6], 1, 0);
    vec[12] = mkv(0, 0, 0, 0, 32'h1C, prog[7], 1, 0);
    vec[13] = mkv(0, 1, 1, 1, 32'h20, prog[8], 1, 0);
    vec[14] = mkv(0, 1, 0, 0, 32'h40, prog[16], 1, 0);
    vec[15] = mkv(0, 0, 0, 0, 32'h40, 32'h0, 0, 1);
    vec[16] = mkv(0, 1, 0, 0, 32'h40, 32'h0, 0, 1);

    #1;
    chk("reset_pc", PC, 32'h0);
    chk("reset_running", {31'b0, running}, 32'h0);
    chk("reset_fault", {31'b0, fault}, 32'h0);
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      load_en = 1'b1; load_addr = AW'(i); load_data = prog[i];
      start = (i == 16);
    end
    @(negedge clk);
    chk("boot_pc_frozen", PC, 32'h0);
    idle_inputs();

    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      stall = vec[i].stall; Jump = vec[i].jump; Branch = vec[i].branch; Zero = vec[i].zero;
      #1;
      chk($sformatf("v%0d_pc", i), PC, vec[i].pc);
      chk($sformatf("v%0d_pcplus4", i), PCPlus4, vec[i].pc + 32'd4);
      chk($sformatf("v%0d_instr", i), Instr, vec[i].instr);
      chk($sformatf("v%0d_opcode", i), {26'b0, Opcode}, {26'b0, vec[i].instr[31:26]});
      chk($sformatf("v%0d_funct", i), {26'b0, Funct}, {26'b0, vec[i].instr[5:0]});
      chk($sformatf("v%0d_imm", i), {16'b0, Imm}, {16'b0, vec[i].instr[15:0]});
      chk($sformatf("v%0d_running", i), {31'b0, running}, {31'b0, vec[i].run});
      chk($sformatf("v%0d_fault", i), {31'b0, fault}, {31'b0, vec[i].flt});
    end

    // asynchronous reset out of FAULT
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("fault_rst_fault", {31'b0, fault}, 32'h0);
    chk("fault_rst_pc", PC, 32'h0);
    chk("fault_rst_running", {31'b0, running}, 32'h0);
    chk("fault_rst_instr", Instr, 32'h0);
    #1;
    rst_n = 1'b1;

    // load_en in RUN is ignored; reset mid-RUN re-runs the retained program
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; load_en = 1'b1; load_addr = '0; load_data = 32'hDEAD_BEEF;
    @(negedge clk); load_en = 1'b0;
    @(negedge clk);
    chk("run_pc8", PC, 32'h08);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_pc", PC, 32'h0);
    chk("midrun_rst_running", {31'b0, running}, 32'h0);
    #1;
    rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    chk("rerun_pc", PC, 32'h0);
    chk("rerun_instr_kept", Instr, 32'h2008_0005);
    chk("rerun_running", {31'b0, running}, 32'h1);
    @(negedge clk);
    #1;
    chk("rerun_pc4", PC, 32'h04);

    // randomized phase: fresh program, reference model tracks everything
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        3: begin w[25:16] = '0; w[15:8] = 8'hFF; end
        default: w[25:8] = '0;
      endcase
      m_mem[i] = w;
      @(negedge clk);
      load_en = 1'b1; load_addr = AW'(i); load_data = w;
    end
    m_state = 0;
    m_pc = 32'h0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 32) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_state = 0;
        m_pc = 32'h0;
      end
      start     = ($urandom_range(0, 3) == 0);
      load_en   = ($urandom_range(0, 4) == 0);
      load_addr = AW'($urandom);
      load_data = $urandom;
      stall     = ($urandom_range(0, 4) == 0);
      Jump      = ($urandom_range(0, 6) == 0);
      Branch    = ($urandom_range(0, 2) == 0);
      Zero      = 1'($urandom_range(0, 1));
      #1;
      exp_instr = (m_state == 1) ? m_mem[(m_pc / 4) % DEPTH] : 32'h0;
      chk("rnd_pc", PC, m_pc);
      chk("rnd_instr", Instr, exp_instr);
      chk("rnd_running", {31'b0, running}, {31'b0, m_state == 1});
      chk("rnd_fault", {31'b0, fault}, {31'b0, m_state == 2});

      if (m_state == 0) begin
        if (load_en) m_mem[load_addr] = load_data;
        if (start) m_state = 1;
      end else if (m_state == 1 && !stall) begin
        p4 = m_pc + 32'd4;
        if (Jump) nxt = (p4 & 32'hF000_0000) | ((exp_instr & 32'h03FF_FFFF) * 4);
        else if (Branch && Zero) begin
          off = int'($signed(exp_instr[15:0]));
          nxt = p4 + 32'(off * 4);
        end else nxt = p4;
        if ((nxt % 4) != 0 || nxt >= 32'(4 * DEPTH)) m_state = 2;
        else m_pc = nxt;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
